rob_param: RTL and testbench

Parametrised reorder buffer for the out-of-order RISC-V core: a circular queue of `DEPTH` in-flight instructions, allocated in program order by decode and completed out of order through `WB_CH` writeback channels. It retires one instruction per cycle in order to the register file, runs a commit/acknowledge handshake with the load-store buffer for stores, and raises a one-cycle flush on branch misprediction or indirect jump. It sits between decode/rename and the register file, LSB and fetch unit.

---
 rtl/rob_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_rob_param.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// rob_param: reorder buffer; in-order allocate, out-of-order writeback, in-order retire.
// Latency: lookup/bypass combinational; commit pulses registered one cycle after head is done.
// Backpressure: full blocks allocation, a store holds the head until st_ack, rdy low freezes all.
module rob_param #(
  parameter int  DEPTH  = 16,
  parameter int  WB_CH  = 2,
  parameter int  DATA_W = 32,
  parameter int  ADDR_W = 32,
  parameter int  REG_W  = 5,
  localparam int TW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  // decode / allocation
  input  logic                    dec_valid,
  input  logic [1:0]              dec_kind,
  input  logic [REG_W-1:0]        dec_rd,
  input  logic [ADDR_W-1:0]       dec_pc,
  input  logic                    dec_pred_taken,
  input  logic                    dec_done,
  input  logic [DATA_W-1:0]       dec_val,
  output logic                    full,
  output logic [TW-1:0]           dec_tag,
  // operand lookup
  input  logic [TW-1:0]           rs1_tag,
  input  logic [TW-1:0]           rs2_tag,
  output logic                    rs1_ready,
  output logic                    rs2_ready,
  output logic [DATA_W-1:0]       rs1_val,
  output logic [DATA_W-1:0]       rs2_val,
  // writeback channels
  input  logic [WB_CH-1:0]        wb_valid,
  input  logic [WB_CH*TW-1:0]     wb_tag,
  input  logic [WB_CH*DATA_W-1:0] wb_val,
  input  logic [WB_CH-1:0]        wb_taken,
  input  logic [WB_CH*ADDR_W-1:0] wb_target,
  // register commit
  output logic                    cm_valid,
  output logic [REG_W-1:0]        cm_rd,
  output logic [DATA_W-1:0]       cm_val,
  output logic [TW-1:0]           cm_tag,
  // store commit handshake
  output logic                    st_commit,
  output logic [TW-1:0]           st_tag,
  input  logic                    st_ack,
  // predictor update and redirect
  output logic                    bp_valid,
  output logic [ADDR_W-1:0]       bp_pc,
  output logic                    bp_taken,
  output logic                    flush,
  output logic [ADDR_W-1:0]       flush_pc
);

  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;

  typedef enum logic {RUN, ST_WAIT} state_t;

  // Entry storage
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  pred_q;
  logic [DEPTH-1:0]  taken_q;
  logic [1:0]        kind_q [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [ADDR_W-1:0] tgt_q  [DEPTH];

  // Queue pointers and occupancy
  logic [TW-1:0]     head;
  logic [TW-1:0]     tail;
  logic [TW:0]       count;
  state_t            state;

  logic              head_rdy;
  logic              alloc_ok;
  logic              retire;

  assign full     = (count == (TW+1)'(DEPTH));
  assign dec_tag  = tail;
  assign head_rdy = busy_q[head] && done_q[head];
  // Nothing is accepted during the squash cycle; full alone gates allocation.
  assign alloc_ok = rdy && !flush && dec_valid && !full;

  // Operand lookup: registered entry state, overridden by any same-cycle writeback (last channel wins)
  always_comb begin
    rs1_ready = done_q[rs1_tag];
    rs1_val   = val_q[rs1_tag];
    rs2_ready = done_q[rs2_tag];
    rs2_val   = val_q[rs2_tag];
    for (int k = 0; k < WB_CH; k++) begin
      if (wb_valid[k] && (wb_tag[k*TW +: TW] == rs1_tag)) begin
        rs1_ready = 1'b1;
        rs1_val   = wb_val[k*DATA_W +: DATA_W];
      end
      if (wb_valid[k] && (wb_tag[k*TW +: TW] == rs2_tag)) begin
        rs2_ready = 1'b1;
        rs2_val   = wb_val[k*DATA_W +: DATA_W];
      end
    end
  end

  // Retire decision: non-store done head in RUN, or an acknowledged store in ST_WAIT
  always_comb begin
    retire = 1'b0;
    if (rdy && !flush) begin
      if (state == RUN) begin
        retire = head_rdy && (kind_q[head] != K_ST);
      end else begin
        retire = st_ack;
      end
    end
  end

  // Entry updates, pointers, commit FSM and registered commit-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      done_q    <= '0;
      pred_q    <= '0;
      taken_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i] <= K_REG;
        rd_q[i]   <= '0;
        pc_q[i]   <= '0;
        val_q[i]  <= '0;
        tgt_q[i]  <= '0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= RUN;
      cm_valid  <= 1'b0;
      cm_rd     <= '0;
      cm_val    <= '0;
      cm_tag    <= '0;
      st_commit <= 1'b0;
      st_tag    <= '0;
      bp_valid  <= 1'b0;
      bp_pc     <= '0;
      bp_taken  <= 1'b0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else if (rdy) begin
      // Pulses last exactly one active cycle.
      cm_valid  <= 1'b0;
      st_commit <= 1'b0;
      bp_valid  <= 1'b0;
      flush     <= 1'b0;

      if (flush) begin
        // Squash everything in flight; the redirect restarts allocation at tag 0.
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        busy_q <= '0;
        state  <= RUN;
      end else begin
        // Writeback: later channels override earlier ones on a shared tag.
        for (int k = 0; k < WB_CH; k++) begin
          if (wb_valid[k] && busy_q[wb_tag[k*TW +: TW]]) begin
            done_q[wb_tag[k*TW +: TW]]  <= 1'b1;
            val_q[wb_tag[k*TW +: TW]]   <= wb_val[k*DATA_W +: DATA_W];
            taken_q[wb_tag[k*TW +: TW]] <= wb_taken[k];
            tgt_q[wb_tag[k*TW +: TW]]   <= wb_target[k*ADDR_W +: ADDR_W];
          end
        end

        // Allocation at the tail; the tail entry is never busy here, so no writeback collides.
        if (alloc_ok) begin
          busy_q[tail]  <= 1'b1;
          done_q[tail]  <= dec_done;
          kind_q[tail]  <= dec_kind;
          rd_q[tail]    <= dec_rd;
          pc_q[tail]    <= dec_pc;
          pred_q[tail]  <= dec_pred_taken;
          taken_q[tail] <= 1'b0;
          val_q[tail]   <= dec_val;
          tgt_q[tail]   <= '0;
          tail          <= tail + TW'(1);
        end

        // Retirement frees the head entry.
        if (retire) begin
          busy_q[head] <= 1'b0;
          head         <= head + TW'(1);
        end

        count <= count + (TW+1)'(alloc_ok) - (TW+1)'(retire);

        case (state)
          RUN: begin
            if (head_rdy) begin
              case (kind_q[head])
                K_REG: begin
                  cm_valid <= 1'b1;
                  cm_rd    <= rd_q[head];
                  cm_val   <= val_q[head];
                  cm_tag   <= head;
                end
                K_JMP: begin
                  cm_valid <= 1'b1;
                  cm_rd    <= rd_q[head];
                  cm_val   <= val_q[head];
                  cm_tag   <= head;
                  flush    <= 1'b1;
                  flush_pc <= tgt_q[head];
                end
                K_BR: begin
                  bp_valid <= 1'b1;
                  bp_pc    <= pc_q[head];
                  bp_taken <= taken_q[head];
                  if (taken_q[head] != pred_q[head]) begin
                    flush    <= 1'b1;
                    flush_pc <= tgt_q[head];
                  end
                end
                K_ST: begin
                  // Hand the store to the LSB and hold the head until it acknowledges.
                  st_commit <= 1'b1;
                  st_tag    <= head;
                  state     <= ST_WAIT;
                end
                default: ;
              endcase
            end
          end
          ST_WAIT: begin
            if (st_ack) begin
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: self-checking bench for rob_param (DEPTH=16, two writeback channels).
// Inputs are driven 1ns after the rising edge; outputs are checked there or on the falling edge.
// A commit scoreboard pops expected {tag, rd, val} for every cm_valid pulse.
module tb_rob_param;
  localparam int DEPTH  = 16;
  localparam int WB_CH  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int TW     = 4;

  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, rdy;
  logic                    dec_valid, dec_pred_taken, dec_done;
  logic [1:0]              dec_kind;
  logic [REG_W-1:0]        dec_rd;
  logic [ADDR_W-1:0]       dec_pc;
  logic [DATA_W-1:0]       dec_val;
  logic                    full;
  logic [TW-1:0]           dec_tag, rs1_tag, rs2_tag;
  logic                    rs1_ready, rs2_ready;
  logic [DATA_W-1:0]       rs1_val, rs2_val;
  logic [WB_CH-1:0]        wb_valid, wb_taken;
  logic [WB_CH*TW-1:0]     wb_tag;
  logic [WB_CH*DATA_W-1:0] wb_val;
  logic [WB_CH*ADDR_W-1:0] wb_target;
  logic                    cm_valid, st_commit, st_ack, bp_valid, bp_taken, flush;
  logic [REG_W-1:0]        cm_rd;
  logic [DATA_W-1:0]       cm_val;
  logic [TW-1:0]           cm_tag, st_tag;
  logic [ADDR_W-1:0]       bp_pc, flush_pc;

  rob_param #(.DEPTH(DEPTH), .WB_CH(WB_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dec_valid(dec_valid), .dec_kind(dec_kind), .dec_rd(dec_rd), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_done(dec_done), .dec_val(dec_val),
    .full(full), .dec_tag(dec_tag),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_taken(wb_taken), .wb_target(wb_target),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_tag(cm_tag),
    .st_commit(st_commit), .st_tag(st_tag), .st_ack(st_ack),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TW-1:0]     tag;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Lookup vector: writeback inputs, lookup tags, expected ready/value
  typedef struct {
    logic [1:0]        v;
    logic [TW-1:0]     t0, t1;
    logic [DATA_W-1:0] d0, d1;
    logic [TW-1:0]     q1, q2;
    logic              r1, r2;
    logic [DATA_W-1:0] e1, e2;
  } lk_t;
  lk_t lk [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_clear();
    wb_valid  = '0;
    wb_tag    = '0;
    wb_val    = '0;
    wb_taken  = '0;
    wb_target = '0;
  endtask

  task automatic wb_set(input int ch, input logic [TW-1:0] tag, input logic [DATA_W-1:0] val,
                        input logic tk, input logic [ADDR_W-1:0] tgt);
    wb_valid[ch]                   = 1'b1;
    wb_tag[ch*TW +: TW]            = tag;
    wb_val[ch*DATA_W +: DATA_W]    = val;
    wb_taken[ch]                   = tk;
    wb_target[ch*ADDR_W +: ADDR_W] = tgt;
    foreach (exp_q[i]) if (exp_q[i].tag == tag) exp_q[i].val = val;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [REG_W-1:0] rd, input logic [ADDR_W-1:0] pc,
                       input logic pred, input logic done, input logic [DATA_W-1:0] val,
                       input int exp_tag, input bit push);
    chk("dec_tag", 64'(dec_tag), 64'(exp_tag));
    dec_valid      = 1'b1;
    dec_kind       = kind;
    dec_rd         = rd;
    dec_pc         = pc;
    dec_pred_taken = pred;
    dec_done       = done;
    dec_val        = val;
    if (push) exp_q.push_back('{tag: TW'(exp_tag), rd: rd, val: val});
    cycle();
    dec_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (dut.count != 0 && n < 100) begin
      cycle();
      n++;
    end
    chk(name, 64'(dut.count), 64'd0);
  endtask

  // Commit scoreboard
  always @(negedge clk) begin
    if (!rst && cm_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected: tag %0d committed, none expected", cm_tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_tag", 64'(cm_tag), 64'(mon_e.tag));
        chk("commit_rd",  64'(cm_rd),  64'(mon_e.rd));
        chk("commit_val", 64'(cm_val), 64'(mon_e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; st_ack = 1'b0;
    dec_valid = 1'b0; dec_kind = K_REG; dec_rd = '0; dec_pc = '0;
    dec_pred_taken = 1'b0; dec_done = 1'b0; dec_val = '0;
    rs1_tag = '0; rs2_tag = '0;
    wb_clear();
    repeat (3) cycle();
    chk("rst_cm_valid",  64'(cm_valid),  64'd0);
    chk("rst_st_commit", 64'(st_commit), 64'd0);
    chk("rst_bp_valid",  64'(bp_valid),  64'd0);
    chk("rst_flush",     64'(flush),     64'd0);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_dec_tag",   64'(dec_tag),   64'd0);
    chk("rst_count",     64'(dut.count), 64'd0);
    rst = 1'b0;

    // Fill: 16 pending reg-writes, then a 17th that must be dropped
    for (int i = 0; i < 16; i++) alloc(K_REG, REG_W'(i + 1), ADDR_W'(i * 4), 1'b0, 1'b0, '0, i, 1'b1);
    chk("fill_full",  64'(full),      64'd1);
    chk("fill_count", 64'(dut.count), 64'd16);
    alloc(K_REG, 5'd31, 32'h40, 1'b0, 1'b0, '0, 0, 1'b0);
    chk("over_count", 64'(dut.count), 64'd16);
    chk("over_tag",   64'(dec_tag),   64'd0);

    // Combinational lookup/bypass table (no clock edge during these vectors)
    lk[0] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,  4'd7, 4'd2, 1'b0, 1'b0, 32'h0,  32'h0};
    lk[1] = '{2'b11, 4'd5, 4'd5, 32'hAA,   32'hBB, 4'd5, 4'd5, 1'b1, 1'b1, 32'hBB, 32'hBB};
    lk[2] = '{2'b01, 4'd4, 4'd0, 32'h44,   32'h0,  4'd4, 4'd3, 1'b1, 1'b0, 32'h44, 32'h0};
    lk[3] = '{2'b11, 4'd9, 4'd6, 32'h99,   32'h66, 4'd6, 4'd9, 1'b1, 1'b1, 32'h66, 32'h99};
    lk[4] = '{2'b10, 4'd3, 4'd3, 32'h3030, 32'h33, 4'd3, 4'd2, 1'b1, 1'b0, 32'h33, 32'h0};
    for (int i = 0; i < 5; i++) begin
      wb_valid = lk[i].v;
      wb_tag   = {lk[i].t1, lk[i].t0};
      wb_val   = {lk[i].d1, lk[i].d0};
      rs1_tag  = lk[i].q1;
      rs2_tag  = lk[i].q2;
      #1;
      chk("lk_rs1_ready", 64'(rs1_ready), 64'(lk[i].r1));
      chk("lk_rs2_ready", 64'(rs2_ready), 64'(lk[i].r2));
      if (lk[i].r1) chk("lk_rs1_val", 64'(rs1_val), 64'(lk[i].e1));
      if (lk[i].r2) chk("lk_rs2_val", 64'(rs2_val), 64'(lk[i].e2));
    end
    wb_clear();

    // Same-tag writeback on both channels: channel 1 wins, visible now and after the edge
    wb_set(0, 4'd5, 32'hAA, 1'b0, '0);
    wb_set(1, 4'd5, 32'hBB, 1'b0, '0);
    rs1_tag = 4'd5;
    #1;
    chk("dual_byp_ready", 64'(rs1_ready), 64'd1);
    chk("dual_byp_val",   64'(rs1_val),   64'hBB);
    cycle();
    wb_clear();
    #1;
    chk("dual_reg_ready", 64'(rs1_ready), 64'd1);
    chk("dual_reg_val",   64'(rs1_val),   64'hBB);

    // Out-of-order writebacks 3,0,1,2 -> in-order commits 0,1,2,3 on consecutive cycles
    wb_set(0, 4'd3, 32'h1003, 1'b0, '0); cycle(); wb_clear();
    wb_set(0, 4'd0, 32'h1000, 1'b0, '0); cycle(); wb_clear();
    wb_set(0, 4'd1, 32'h1001, 1'b0, '0); cycle(); wb_clear();
    chk("ooo_cm0_valid", 64'(cm_valid), 64'd1);
    chk("ooo_cm0_tag",   64'(cm_tag),   64'd0);
    wb_set(0, 4'd2, 32'h1002, 1'b0, '0); cycle(); wb_clear();
    chk("ooo_cm1_tag",   64'(cm_tag),   64'd1);
    cycle();
    chk("ooo_cm2_tag",   64'(cm_tag),   64'd2);
    cycle();
    chk("ooo_cm3_tag",   64'(cm_tag),   64'd3);
    chk("ooo_count",     64'(dut.count), 64'd12);
    cycle();
    chk("ooo_stall",     64'(cm_valid), 64'd0);

    // Complete the rest, then four done-at-allocation entries wrap to tags 0..3
    wb_set(0, 4'd4, 32'h1004, 1'b0, '0); cycle(); wb_clear();
    for (int t = 6; t < 16; t++) begin
      wb_set(1, TW'(t), DATA_W'(32'h1000 + t), 1'b0, '0);
      cycle();
      wb_clear();
    end
    for (int i = 0; i < 4; i++) alloc(K_REG, REG_W'(20 + i), 32'h80, 1'b0, 1'b1, DATA_W'(32'h2000 + i), i, 1'b1);
    drain("wrap_drain");

    // Store at head with a spurious ack in RUN, then a late ack three cycles after st_commit
    st_ack = 1'b1;
    alloc(K_ST,  5'd0, 32'h100, 1'b0, 1'b1, '0,     4, 1'b0);
    alloc(K_REG, 5'd9, 32'h104, 1'b0, 1'b1, 32'h77, 5, 1'b1);
    st_ack = 1'b0;
    chk("st_commit",  64'(st_commit), 64'd1);
    chk("st_tag",     64'(st_tag),    64'd4);
    chk("st_count0",  64'(dut.count), 64'd2);
    cycle();
    chk("st_pulse",   64'(st_commit), 64'd0);
    chk("st_count1",  64'(dut.count), 64'd2);
    cycle();
    chk("st_count2",  64'(dut.count), 64'd2);
    chk("st_no_cm",   64'(cm_valid),  64'd0);
    cycle();
    chk("st_count3",  64'(dut.count), 64'd2);
    st_ack = 1'b1;
    cycle();
    st_ack = 1'b0;
    chk("st_retired", 64'(dut.count), 64'd1);
    chk("st_cm_wait", 64'(cm_valid),  64'd0);
    cycle();
    chk("st_next_cm",  64'(cm_valid), 64'd1);
    chk("st_next_tag", 64'(cm_tag),   64'd5);
    chk("st_count4",   64'(dut.count), 64'd0);

    // Mispredicted branch: flush squashes a done younger entry and a same-cycle allocation
    alloc(K_BR,  5'd0, 32'h200, 1'b0, 1'b0, '0,     6, 1'b0);
    alloc(K_REG, 5'd3, 32'h204, 1'b0, 1'b1, 32'h55, 7, 1'b0);
    wb_set(0, 4'd6, 32'h0, 1'b1, 32'h1000); cycle(); wb_clear();
    cycle();
    chk("br_bp_valid", 64'(bp_valid), 64'd1);
    chk("br_bp_taken", 64'(bp_taken), 64'd1);
    chk("br_bp_pc",    64'(bp_pc),    64'h200);
    chk("br_flush",    64'(flush),    64'd1);
    chk("br_flush_pc", 64'(flush_pc), 64'h1000);
    chk("br_no_cm",    64'(cm_valid), 64'd0);
    dec_valid = 1'b1; dec_kind = K_REG; dec_done = 1'b1;
    cycle();
    dec_valid = 1'b0;
    chk("br_flush_end", 64'(flush),     64'd0);
    chk("br_count",     64'(dut.count), 64'd0);
    chk("br_dec_tag",   64'(dec_tag),   64'd0);
    cycle();
    chk("br_squashed",  64'(cm_valid),  64'd0);

    // Correctly predicted branch: predictor update, no flush
    alloc(K_BR, 5'd0, 32'h300, 1'b1, 1'b0, '0, 0, 1'b0);
    wb_set(1, 4'd0, 32'h0, 1'b1, 32'h2000); cycle(); wb_clear();
    cycle();
    chk("brok_bp_valid", 64'(bp_valid), 64'd1);
    chk("brok_bp_pc",    64'(bp_pc),    64'h300);
    chk("brok_no_flush", 64'(flush),    64'd0);

    // Jump: commits its link value and redirects
    alloc(K_JMP, 5'd1, 32'h304, 1'b0, 1'b0, '0, 1, 1'b1);
    wb_set(0, 4'd1, 32'h308, 1'b0, 32'h4000); cycle(); wb_clear();
    cycle();
    chk("jmp_cm_valid", 64'(cm_valid), 64'd1);
    chk("jmp_flush",    64'(flush),    64'd1);
    chk("jmp_flush_pc", 64'(flush_pc), 64'h4000);
    cycle();
    chk("jmp_count",    64'(dut.count), 64'd0);
    chk("jmp_dec_tag",  64'(dec_tag),   64'd0);

    // Full ROB: retirement and allocation in the same cycle -> allocation rejected
    for (int i = 0; i < 16; i++) alloc(K_REG, REG_W'(i), 32'h600, 1'b0, 1'b0, '0, i, 1'b1);
    chk("full2_count", 64'(dut.count), 64'd16);
    wb_set(0, 4'd0, 32'h3000, 1'b0, '0); cycle(); wb_clear();
    dec_valid = 1'b1; dec_kind = K_REG; dec_done = 1'b1;
    cycle();
    dec_valid = 1'b0;
    chk("full2_count_after", 64'(dut.count), 64'd15);
    chk("full2_not_full",    64'(full),      64'd0);
    chk("full2_dec_tag",     64'(dec_tag),   64'd0);
    chk("full2_cm_tag",      64'(cm_tag),    64'd0);
    for (int t = 1; t < 16; t++) begin
      wb_set(1, TW'(t), DATA_W'(32'h3000 + t), 1'b0, '0);
      cycle();
      wb_clear();
    end
    drain("full2_drain");
    cycle();

    // rdy low: allocation request is held off
    rdy = 1'b0;
    dec_valid = 1'b1; dec_kind = K_REG; dec_done = 1'b0;
    cycle();
    cycle();
    dec_valid = 1'b0;
    chk("rdy_count",   64'(dut.count), 64'd0);
    chk("rdy_dec_tag", 64'(dec_tag),   64'd0);
    rdy = 1'b1;
    cycle();

    // Reset while a store waits for its ack: no re-issue, outputs back to zero
    alloc(K_ST, 5'd0, 32'h500, 1'b0, 1'b1, '0, 0, 1'b0);
    cycle();
    chk("rst_st_issue", 64'(st_commit), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_count",    64'(dut.count), 64'd0);
    chk("rst_mid_flush_pc", 64'(flush_pc),  64'd0);
    chk("rst_mid_cm_val",   64'(cm_val),    64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_st", 64'(st_commit), 64'd0);
      cycle();
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
